tomasulo_cdb_sch: RTL and testbench

//  Central CDB slot scheduler for the Tomasulo core. Owns the future-slot reservation

---
 rtl/tomasulo_pkg.sv | 19 +
 rtl/tomasulo_cdb_sch.sv | 124 ++++++++++++
 tb/tb_tomasulo_cdb_sch.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/tomasulo_pkg.sv
// Shared Tomasulo core types: FU identifiers, the CDB reservation vector,
// and the default issue-to-CDB latency table.
package tomasulo_pkg;

  localparam int CDB_REQ_N = 4;
  localparam int CDB_SCH_N = 8;

  // Entries are listed FU0 first (leftmost), so FU0=2, FU1=2, FU2=3, FU3=5.
  localparam logic [CDB_REQ_N*4-1:0] CDB_LAT = {4'd2, 4'd2, 4'd3, 4'd5};

  typedef logic [$clog2(CDB_REQ_N)-1:0] fu_id_t;
  typedef logic [CDB_SCH_N-1:0]         cdb_sch_t;

  typedef struct packed {
    logic   vld;
    fu_id_t id;
  } cdb_slot_t;

endpackage

// File: rtl/tomasulo_cdb_sch.sv
// Central CDB slot scheduler: rotating-priority arbitration of station requests
// into future CDB slots, plus a per-slot owner record that drains one slot per cycle.
module tomasulo_cdb_sch
  import tomasulo_pkg::*;
#(
  parameter int                 REQ_N = CDB_REQ_N,
  parameter int                 SCH_N = CDB_SCH_N,
  parameter logic [REQ_N*4-1:0] LAT   = CDB_LAT
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [REQ_N-1:0]         req,
  output logic [REQ_N-1:0]         gnt,
  output logic [SCH_N-1:0]         sch_r,
  output logic                     cdb_own_vld,
  output logic [$clog2(REQ_N)-1:0] cdb_own_id
);

  typedef logic [$clog2(SCH_N)-1:0] slot_idx_t;

  function automatic int lat_of(input int i);
    return int'(LAT[4*(REQ_N-1-i) +: 4]);
  endfunction

  generate
    if (REQ_N < 2) begin : g_req_chk
      $error("tomasulo_cdb_sch: REQ_N must be at least 2");
    end
    if ($clog2(REQ_N) != $bits(fu_id_t) || SCH_N != $bits(cdb_sch_t)) begin : g_pkg_chk
      $error("tomasulo_cdb_sch: REQ_N/SCH_N must match tomasulo_pkg types");
    end
    for (genvar g = 0; g < REQ_N; g++) begin : g_lat_chk
      if (lat_of(g) < 1 || lat_of(g) > SCH_N - 1) begin : g_bad
        $error("tomasulo_cdb_sch: LAT entry out of range 1..SCH_N-1");
      end
    end
  endgenerate

  // A requester wins only if its target slot is neither reserved nor taken earlier in this scan.
  function automatic logic [REQ_N-1:0] rr_scan(input logic [REQ_N-1:0] r,
                                               input logic [SCH_N-1:0] busy,
                                               input fu_id_t           ptr);
    logic [SCH_N-1:0] taken;
    logic [REQ_N-1:0] g;
    fu_id_t           idx;
    slot_idx_t        slot;
    taken = busy;
    g     = '0;
    for (int k = 0; k < REQ_N; k++) begin
      idx  = fu_id_t'((int'(ptr) + k) % REQ_N);
      slot = slot_idx_t'(lat_of(int'(idx)));
      if (r[idx] && !taken[slot]) begin
        g[idx]      = 1'b1;
        taken[slot] = 1'b1;
      end
    end
    return g;
  endfunction

  cdb_slot_t [SCH_N-1:0] slots_q, slots_d;
  fu_id_t                rr_ptr_q, rr_ptr_d;
  logic [SCH_N-1:0]      claim;

  always_comb begin
    for (int k = 0; k < SCH_N; k++) begin
      sch_r[k] = slots_q[k].vld;
    end
  end

  assign gnt         = rst_n ? rr_scan(req, sch_r, rr_ptr_q) : '0;
  assign cdb_own_vld = slots_q[0].vld;
  assign cdb_own_id  = slots_q[0].vld ? slots_q[0].id : '0;

  always_comb begin
    logic   found;
    fu_id_t idx;
    found    = 1'b0;
    idx      = '0;
    rr_ptr_d = rr_ptr_q;
    for (int k = 0; k < REQ_N; k++) begin
      idx = fu_id_t'((int'(rr_ptr_q) + k) % REQ_N);
      if (!found && gnt[idx]) begin
        found    = 1'b1;
        rr_ptr_d = fu_id_t'((int'(idx) + 1) % REQ_N);
      end
    end
  end

  // Slot k+1 becomes slot k; a grant of latency L lands in slot L-1 after the shift.
  always_comb begin
    slot_idx_t s;
    s       = '0;
    slots_d = '0;
    claim   = '0;
    for (int k = 0; k < SCH_N - 1; k++) begin
      slots_d[k] = slots_q[k+1];
    end
    for (int i = 0; i < REQ_N; i++) begin
      if (gnt[i]) begin
        s              = slot_idx_t'(lat_of(i) - 1);
        claim[s]       = 1'b1;
        slots_d[s].vld = 1'b1;
        slots_d[s].id  = fu_id_t'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slots_q  <= '0;
      rr_ptr_q <= '0;
    end else begin
      slots_q  <= slots_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (((sch_r >> 1) & claim) == '0);
    end
  end

endmodule

// File: tb/tb_tomasulo_cdb_sch.sv
// Directed and scoreboarded checks for the CDB slot scheduler.
module tb_tomasulo_cdb_sch;
  import tomasulo_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [7:0] sch_r;
  logic       cdb_own_vld;
  logic [1:0] cdb_own_id;

  int errors = 0;
  int checks = 0;

  localparam int TB_LAT [4] = '{2, 2, 3, 5};

  logic       pend_vld [0:15];
  logic [1:0] pend_id  [0:15];

  tomasulo_cdb_sch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .gnt         (gnt),
    .sch_r       (sch_r),
    .cdb_own_vld (cdb_own_vld),
    .cdb_own_id  (cdb_own_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  task checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task checkCdb(input string tag, input logic vld, input logic [1:0] id);
    checkOutput({tag, "_vld"}, 32'(cdb_own_vld), 32'(vld));
    checkOutput({tag, "_id"}, 32'(cdb_own_id), 32'(id));
  endtask

  // One cycle: drive at the falling edge, let comb logic settle, then compare.
  task applyStimulus(input logic r, input logic [3:0] q);
    @(negedge clk);
    rst_n = r;
    req   = q;
    #1;
  endtask

  task doReset();
    applyStimulus(1'b0, 4'b0000);
    applyStimulus(1'b0, 4'b0000);
  endtask

  initial begin
    logic [3:0] q;
    logic [7:0] exp_sch;
    logic       any_elig;
    rst_n = 1'b0;
    req   = 4'b1111;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_gnt", 32'(gnt), 32'h0);
    checkOutput("rst_sch", 32'(sch_r), 32'h0);
    checkCdb("rst_own", 1'b0, 2'd0);

    applyStimulus(1'b1, 4'b0001);
    checkOutput("t1_gnt", 32'(gnt), 32'b0001);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("t1_sch", 32'(sch_r), 32'b0000_0010);
    applyStimulus(1'b1, 4'b0000);
    checkCdb("t1_own", 1'b1, 2'd0);

    doReset();
    applyStimulus(1'b1, 4'b1000);
    checkOutput("t2_gnt", 32'(gnt), 32'b1000);
    for (int d = 1; d <= 4; d++) begin
      applyStimulus(1'b1, 4'b0000);
      checkCdb($sformatf("t2_idle%0d", d), 1'b0, 2'd0);
    end
    applyStimulus(1'b1, 4'b0000);
    checkCdb("t2_hit", 1'b1, 2'd3);
    applyStimulus(1'b1, 4'b0000);
    checkCdb("t2_after", 1'b0, 2'd0);

    doReset();
    applyStimulus(1'b1, 4'b0011);
    checkOutput("t3_gnt0", 32'(gnt), 32'b0001);
    applyStimulus(1'b1, 4'b0011);
    checkOutput("t3_gnt1", 32'(gnt), 32'b0010);
    applyStimulus(1'b1, 4'b0011);
    checkOutput("t3_gnt2", 32'(gnt), 32'b0001);
    checkCdb("t3_own0", 1'b1, 2'd0);
    applyStimulus(1'b1, 4'b0011);
    checkOutput("t3_gnt3", 32'(gnt), 32'b0010);
    checkCdb("t3_own1", 1'b1, 2'd1);
    applyStimulus(1'b1, 4'b0000);
    checkCdb("t3_own2", 1'b1, 2'd0);

    doReset();
    applyStimulus(1'b1, 4'b1101);
    checkOutput("t4_gnt", 32'(gnt), 32'b1101);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("t4_sch", 32'(sch_r), 32'b0001_0110);
    checkCdb("t4_t1", 1'b0, 2'd0);
    applyStimulus(1'b1, 4'b0000);
    checkCdb("t4_t2", 1'b1, 2'd0);
    applyStimulus(1'b1, 4'b0000);
    checkCdb("t4_t3", 1'b1, 2'd2);
    applyStimulus(1'b1, 4'b0000);
    checkCdb("t4_t4", 1'b0, 2'd0);
    applyStimulus(1'b1, 4'b0000);
    checkCdb("t4_t5", 1'b1, 2'd3);

    // FU3 reserved at t sits in slot 3 at t+2, exactly where an FU2 grant would land.
    doReset();
    applyStimulus(1'b1, 4'b1000);
    checkOutput("t5_gnt", 32'(gnt), 32'b1000);
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0100);
    checkOutput("t5_sch", 32'(sch_r), 32'b0000_1000);
    checkOutput("t5_busy", 32'(gnt), 32'b0000);
    applyStimulus(1'b1, 4'b0100);
    checkOutput("t5_free", 32'(gnt), 32'b0100);
    applyStimulus(1'b1, 4'b0000);
    applyStimulus(1'b1, 4'b0000);
    checkCdb("t5_own3", 1'b1, 2'd3);
    applyStimulus(1'b1, 4'b0000);
    checkCdb("t5_own2", 1'b1, 2'd2);

    doReset();
    applyStimulus(1'b1, 4'b1101);
    checkOutput("t6_gnt", 32'(gnt), 32'b1101);
    applyStimulus(1'b0, 4'b1111);
    checkOutput("t6_rst_gnt", 32'(gnt), 32'b0000);
    applyStimulus(1'b1, 4'b0000);
    checkOutput("t6_sch", 32'(sch_r), 32'h0);
    checkCdb("t6_own", 1'b0, 2'd0);
    for (int d = 3; d <= 6; d++) begin
      applyStimulus(1'b1, 4'b0000);
      checkCdb($sformatf("t6_drain%0d", d), 1'b0, 2'd0);
    end

    doReset();
    for (int k = 0; k < 16; k++) begin
      pend_vld[k] = 1'b0;
      pend_id[k]  = 2'd0;
    end
    for (int n = 0; n < 3000; n++) begin
      q = 4'($urandom_range(0, 15));
      applyStimulus(1'b1, q);
      for (int k = 0; k < 8; k++) exp_sch[k] = pend_vld[k];
      checkOutput("rnd_sch", 32'(sch_r), 32'(exp_sch));
      checkCdb("rnd_own", pend_vld[0], pend_vld[0] ? pend_id[0] : 2'd0);
      checkOutput("rnd_gnt_req", 32'(gnt & ~q), 32'h0);
      any_elig = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (q[i] && !pend_vld[TB_LAT[i]]) any_elig = 1'b1;
      end
      if (any_elig) checkOutput("rnd_live", 32'(gnt != 4'b0000), 32'h1);
      for (int i = 0; i < 4; i++) begin
        if (gnt[i]) begin
          checkOutput($sformatf("rnd_slot_free%0d", i), 32'(pend_vld[TB_LAT[i]]), 32'h0);
          pend_vld[TB_LAT[i]] = 1'b1;
          pend_id[TB_LAT[i]]  = 2'(i);
        end
      end
      for (int k = 0; k < 15; k++) begin
        pend_vld[k] = pend_vld[k+1];
        pend_id[k]  = pend_id[k+1];
      end
      pend_vld[15] = 1'b0;
      pend_id[15]  = 2'd0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
